// File: rtl/axi_slave_pkg.sv
// Shared encodings for the AXI4 memory responder: burst types, response codes and FSM states.
package axi_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Only these lengths form a legal wrapping burst; anything else falls back to INCR.
  function automatic logic is_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat word address for FIXED / INCR / WRAP bursts; low two address bits are ignored.
module axi_burst_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr_c
);

  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;
  logic              unused_c;

  // For legal wrap lengths (len+1)*4-1 is simply len with two ones appended.
  always_comb begin
    aligned     = {addr[ADDR_W-1:2], 2'b00};
    incr        = aligned + ADDR_W'(4);
    mask        = ADDR_W'({len, 2'b11});
    next_addr_c = incr;
    if (burst == BURST_FIXED) begin
      next_addr_c = aligned;
    end else if ((burst == BURST_WRAP) && is_wrap_len(len)) begin
      next_addr_c = (aligned & ~mask) | (incr & mask);
    end
  end

  assign unused_c = ^addr[1:0];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a 32-bit word register array, with independent write and read burst engines.
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  wr_state_e         w_state, w_state_nxt;
  logic [ADDR_W-1:0] w_addr, w_addr_next_c;
  logic [7:0]        w_len, w_cnt;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              awready_nxt, wready_nxt, bvalid_nxt;
  logic              aw_hs_c, w_hs_c, b_hs_c;
  logic              w_last_beat_c, w_in_range_c, w_beat_err_c;

  rd_state_e         r_state, r_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_addr_next_c, rd_addr_c;
  logic [7:0]        r_len, r_cnt;
  logic [1:0]        r_burst;
  logic              arready_nxt, rvalid_nxt;
  logic              ar_hs_c, r_hs_c, r_more_c;
  logic              rd_ok_c;
  logic [31:0]       rd_word_c;
  logic              unused_c;

  assign aw_hs_c       = s_axi_awvalid && s_axi_awready;
  assign w_hs_c        = s_axi_wvalid && s_axi_wready;
  assign b_hs_c        = s_axi_bvalid && s_axi_bready;
  assign w_last_beat_c = (w_cnt == w_len);
  assign w_in_range_c  = w_addr[ADDR_W-1:2] < WORD_W'(DEPTH);
  assign w_beat_err_c  = !w_in_range_c || (s_axi_wlast != w_last_beat_c);

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
    .addr        (w_addr),
    .len         (w_len),
    .burst       (w_burst),
    .next_addr_c (w_addr_next_c)
  );

  // Write FSM: state and handshake outputs registered together so they read 0 throughout reset.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      w_state       <= w_state_nxt;
      s_axi_awready <= awready_nxt;
      s_axi_wready  <= wready_nxt;
      s_axi_bvalid  <= bvalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs_c) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs_c && w_last_beat_c) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs_c) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready_nxt = 1'b0;
    wready_nxt  = 1'b0;
    bvalid_nxt  = 1'b0;
    unique case (w_state_nxt)
      W_IDLE:  awready_nxt = 1'b1;
      W_DATA:  wready_nxt  = 1'b1;
      W_RESP:  bvalid_nxt  = 1'b1;
      default: ;
    endcase
  end

  // Write burst context; the error flag is sticky across the burst and folded into bresp on the last beat.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      s_axi_bid   <= '0;
      s_axi_bresp <= RESP_OKAY;
      w_addr      <= '0;
      w_len       <= '0;
      w_burst     <= BURST_FIXED;
      w_cnt       <= '0;
      w_err       <= 1'b0;
    end else if (aw_hs_c) begin
      s_axi_bid   <= s_axi_awid;
      w_addr      <= s_axi_awaddr;
      w_len       <= s_axi_awlen;
      w_burst     <= s_axi_awburst;
      w_cnt       <= '0;
      w_err       <= (s_axi_awburst == BURST_RSVD);
    end else if (w_hs_c) begin
      w_addr <= w_addr_next_c;
      w_cnt  <= w_cnt + 8'd1;
      w_err  <= w_err || w_beat_err_c;
      if (w_last_beat_c) begin
        s_axi_bresp <= (w_err || w_beat_err_c) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (w_hs_c && w_in_range_c) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi_wstrb[i]) mem[w_addr[MEM_AW+1:2]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  assign ar_hs_c  = s_axi_arvalid && s_axi_arready;
  assign r_hs_c   = s_axi_rvalid && s_axi_rready;
  assign r_more_c = r_hs_c && !s_axi_rlast;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
    .addr        (r_addr),
    .len         (r_len),
    .burst       (r_burst),
    .next_addr_c (r_addr_next_c)
  );

  // Beat fetch: the start address on AR acceptance, otherwise the next burst address.
  always_comb begin
    if (r_state == R_IDLE) begin
      rd_addr_c = s_axi_araddr;
      rd_ok_c   = s_axi_arburst != BURST_RSVD;
    end else begin
      rd_addr_c = r_addr_next_c;
      rd_ok_c   = r_burst != BURST_RSVD;
    end
    rd_ok_c   = rd_ok_c && (rd_addr_c[ADDR_W-1:2] < WORD_W'(DEPTH));
    rd_word_c = rd_ok_c ? mem[rd_addr_c[MEM_AW+1:2]] : 32'd0;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
    end else begin
      r_state       <= r_state_nxt;
      s_axi_arready <= arready_nxt;
      s_axi_rvalid  <= rvalid_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs_c) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs_c && s_axi_rlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready_nxt = (r_state_nxt == R_IDLE);
    rvalid_nxt  = (r_state_nxt == R_DATA);
  end

  // Read beat registers only move on acceptance, so they hold steady under back-pressure.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rlast <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_burst     <= BURST_FIXED;
      r_cnt       <= '0;
    end else if (ar_hs_c) begin
      s_axi_rid   <= s_axi_arid;
      s_axi_rdata <= rd_word_c;
      s_axi_rresp <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
      s_axi_rlast <= (s_axi_arlen == 8'd0);
      r_addr      <= s_axi_araddr;
      r_len       <= s_axi_arlen;
      r_burst     <= s_axi_arburst;
      r_cnt       <= '0;
    end else if (r_more_c) begin
      s_axi_rdata <= rd_word_c;
      s_axi_rresp <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
      s_axi_rlast <= (8'(r_cnt + 8'd1) == r_len);
      r_addr      <= r_addr_next_c;
      r_cnt       <= r_cnt + 8'd1;
    end
  end

  assign unused_c = ^{s_axi_awsize, s_axi_arsize, rd_addr_c[1:0]};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed vector table, hand sequences and random traffic vs a memory model.
module tb_axi_slave_mem;
  import axi_slave_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned DEPTH  = 128;
  localparam int          TMO    = 300;

  logic              s_axi_aclk = 1'b0;
  logic              s_axi_areset = 1'b0;
  logic [ID_W-1:0]   s_axi_awid = '0;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic [7:0]        s_axi_awlen = '0;
  logic [2:0]        s_axi_awsize = 3'd2;
  logic [1:0]        s_axi_awburst = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata = '0;
  logic [3:0]        s_axi_wstrb = '0;
  logic              s_axi_wlast = 1'b0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b0;
  logic [ID_W-1:0]   s_axi_arid = '0;
  logic [ADDR_W-1:0] s_axi_araddr = '0;
  logic [7:0]        s_axi_arlen = '0;
  logic [2:0]        s_axi_arsize = 3'd2;
  logic [1:0]        s_axi_arburst = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0]     mdl [DEPTH];
  logic [31:0]     got_d [$];
  logic [1:0]      got_r [$];
  logic            got_l [$];
  logic [ID_W-1:0] got_id;

  typedef struct {
    logic [31:0] waddr;
    logic [7:0]  wlen;
    logic [1:0]  wburst;
    logic [31:0] wbase;
    logic [1:0]  exp_b;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic [1:0]  rburst;
    logic [31:0] exp_d [4];
    logic [1:0]  exp_r [4];
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  always #5 s_axi_aclk = ~s_axi_aclk;

  axi_slave_mem #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_areset  (s_axi_areset),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Address of beat i, derived from the burst rules rather than a next-address recurrence.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    logic [31:0] a, total, base;
    a = {start[31:2], 2'b00};
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      total = 32'((int'(len) + 1) * 4);
      base  = (a / total) * total;
      return base + ((a - base + 32'(4 * i)) % total);
    end
    return a + 32'(4 * i);
  endfunction

  function automatic logic [1:0] mdl_write(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [1:0] burst, input logic [31:0] base,
                                           input logic [3:0] strb, input int wl_beat);
    logic err;
    logic [31:0] a, d;
    err = (burst == 2'b11) || (wl_beat != int'(len));
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, burst, i);
      d = base + 32'(i);
      if (a < 32'(DEPTH * 4)) begin
        for (int b = 0; b < 4; b++) if (strb[b]) mdl[int'(a >> 2)][8*b +: 8] = d[8*b +: 8];
      end else begin
        err = 1'b1;
      end
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [ID_W-1:0] id, input logic [31:0] base, input logic [3:0] strb,
                          input int wl_beat, input int bhold,
                          output logic [1:0] bresp, output int beats);
    int n;
    bresp = 2'bxx;
    beats = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < TMO) begin @(negedge s_axi_aclk); n++; end
    if (n >= TMO) begin chk("aw_timeout", 1, 0); s_axi_awvalid = 1'b0; return; end
    @(negedge s_axi_aclk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = base + 32'(i); s_axi_wstrb = strb; s_axi_wlast = (i == wl_beat);
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < TMO) begin @(negedge s_axi_aclk); n++; end
      if (n >= TMO) begin chk("w_timeout", 1, 0); break; end
      @(negedge s_axi_aclk);
      beats++;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("wready_after_burst", s_axi_wready, 0);
    n = 0;
    while (!s_axi_bvalid && n < TMO) begin @(negedge s_axi_aclk); n++; end
    if (n >= TMO) begin chk("b_timeout", 1, 0); return; end
    for (int k = 0; k < bhold; k++) begin
      chk("bvalid_hold", s_axi_bvalid, 1);
      @(negedge s_axi_aclk);
    end
    s_axi_bready = 1'b1;
    bresp = s_axi_bresp;
    chk("bid", s_axi_bid, id);
    @(negedge s_axi_aclk);
    s_axi_bready = 1'b0;
    chk("bvalid_drop", s_axi_bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [ID_W-1:0] id, input bit bp);
    int n;
    bit stall, done;
    logic [35:0] prev;
    got_d.delete(); got_r.delete(); got_l.delete();
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < TMO) begin @(negedge s_axi_aclk); n++; end
    if (n >= TMO) begin chk("ar_timeout", 1, 0); s_axi_arvalid = 1'b0; return; end
    @(negedge s_axi_aclk);
    s_axi_arvalid = 1'b0;
    stall = 1'b0; done = 1'b0; prev = '0;
    for (n = 0; n < TMO && !done; n++) begin
      s_axi_rready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall) chk("r_stable", {s_axi_rvalid, s_axi_rresp, s_axi_rlast, s_axi_rdata}, prev);
      if (s_axi_rvalid && s_axi_rready) begin
        got_d.push_back(s_axi_rdata); got_r.push_back(s_axi_rresp); got_l.push_back(s_axi_rlast);
        got_id = s_axi_rid;
        done = s_axi_rlast || (got_d.size() > int'(len));
      end
      stall = s_axi_rvalid && !s_axi_rready;
      prev  = {1'b1, s_axi_rresp, s_axi_rlast, s_axi_rdata};
      @(negedge s_axi_aclk);
    end
    s_axi_rready = 1'b0;
    if (!done) chk("r_timeout", 1, 0);
    chk("rid", got_id, id);
    chk("rvalid_drop", s_axi_rvalid, 0);
  endtask

  task automatic check_read_mdl(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] a, ed;
    bit ok;
    chk("rd_beats", got_d.size(), int'(len) + 1);
    for (int i = 0; i < got_d.size() && i <= int'(len); i++) begin
      a  = beat_addr(addr, len, burst, i);
      ok = (burst != 2'b11) && (a < 32'(DEPTH * 4));
      ed = ok ? mdl[int'(a >> 2)] : 32'd0;
      chk($sformatf("rd_data@%0h#%0d", addr, i), got_d[i], ed);
      chk($sformatf("rd_resp@%0h#%0d", addr, i), got_r[i], ok ? 2'b00 : 2'b10);
      chk($sformatf("rd_last@%0h#%0d", addr, i), got_l[i], i == int'(len));
    end
  endtask

  initial begin
    logic [1:0]  br;
    int          beats;
    logic [31:0] ra, rb;
    logic [7:0]  rl;
    logic [1:0]  rbu;
    int          wl;

    vt[0] = '{32'h10, 8'd3, 2'b01, 32'd1,    2'b00, 32'h10,  8'd3, 2'b01,
              '{32'd1, 32'd2, 32'd3, 32'd4}, '{2'b00, 2'b00, 2'b00, 2'b00}};
    vt[1] = '{32'h18, 8'd3, 2'b10, 32'd10,   2'b00, 32'h10,  8'd3, 2'b01,
              '{32'd12, 32'd13, 32'd10, 32'd11}, '{2'b00, 2'b00, 2'b00, 2'b00}};
    vt[2] = '{32'h40, 8'd3, 2'b00, 32'h20,   2'b00, 32'h40,  8'd1, 2'b00,
              '{32'h23, 32'h23, 32'h0, 32'h0}, '{2'b00, 2'b00, 2'b00, 2'b00}};
    vt[3] = '{32'h2C, 8'd1, 2'b10, 32'h30,   2'b00, 32'h28,  8'd1, 2'b01,
              '{32'h31, 32'h30, 32'h0, 32'h0}, '{2'b00, 2'b00, 2'b00, 2'b00}};
    vt[4] = '{32'h5C, 8'd2, 2'b10, 32'h50,   2'b00, 32'h5C,  8'd2, 2'b10,
              '{32'h50, 32'h51, 32'h52, 32'h0}, '{2'b00, 2'b00, 2'b00, 2'b00}};
    vt[5] = '{32'h80, 8'd1, 2'b11, 32'h70,   2'b10, 32'h80,  8'd1, 2'b11,
              '{32'h0, 32'h0, 32'h0, 32'h0}, '{2'b10, 2'b10, 2'b00, 2'b00}};
    vt[6] = '{32'h1FC, 8'd1, 2'b01, 32'h90,  2'b10, 32'h1FC, 8'd1, 2'b01,
              '{32'h90, 32'h0, 32'h0, 32'h0}, '{2'b00, 2'b10, 2'b00, 2'b00}};
    vt[7] = '{32'h200, 8'd1, 2'b01, 32'hA0,  2'b10, 32'h200, 8'd1, 2'b01,
              '{32'h0, 32'h0, 32'h0, 32'h0}, '{2'b10, 2'b10, 2'b00, 2'b00}};
    vt[8] = '{32'h7C, 8'd7, 2'b10, 32'hB0,   2'b00, 32'h60,  8'd3, 2'b01,
              '{32'hB1, 32'hB2, 32'hB3, 32'hB4}, '{2'b00, 2'b00, 2'b00, 2'b00}};

    #2 s_axi_areset = 1'b1;
    repeat (3) @(negedge s_axi_aclk);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_wready",  s_axi_wready, 0);
    chk("rst_bvalid",  s_axi_bvalid, 0);
    chk("rst_rvalid",  s_axi_rvalid, 0);
    chk("rst_rlast",   s_axi_rlast, 0);
    chk("rst_rdata",   s_axi_rdata, 0);
    chk("rst_bresp",   s_axi_bresp, 0);
    s_axi_areset = 1'b0;
    @(negedge s_axi_aclk);
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_arready", s_axi_arready, 1);

    // Give every word a known value so later reads of any address can be predicted.
    do_write(32'h0, 8'd127, 2'b01, 3'd1, 32'h5000_0000, 4'hF, 127, 0, br, beats);
    chk("fill_bresp", br, mdl_write(32'h0, 8'd127, 2'b01, 32'h5000_0000, 4'hF, 127));
    chk("fill_beats", beats, 128);

    for (int k = 0; k < NV; k++) begin
      do_write(vt[k].waddr, vt[k].wlen, vt[k].wburst, 3'(k), vt[k].wbase, 4'hF, int'(vt[k].wlen), 0, br, beats);
      void'(mdl_write(vt[k].waddr, vt[k].wlen, vt[k].wburst, vt[k].wbase, 4'hF, int'(vt[k].wlen)));
      chk($sformatf("tbl%0d_bresp", k), br, vt[k].exp_b);
      do_read(vt[k].raddr, vt[k].rlen, vt[k].rburst, 3'(k + 1), 1'b0);
      chk($sformatf("tbl%0d_beats", k), got_d.size(), int'(vt[k].rlen) + 1);
      for (int j = 0; j <= int'(vt[k].rlen) && j < got_d.size(); j++) begin
        chk($sformatf("tbl%0d_rdata%0d", k, j), got_d[j], vt[k].exp_d[j]);
        chk($sformatf("tbl%0d_rresp%0d", k, j), got_r[j], vt[k].exp_r[j]);
        chk($sformatf("tbl%0d_rlast%0d", k, j), got_l[j], j == int'(vt[k].rlen));
      end
    end

    // Byte strobes merge into the existing word.
    do_write(32'h0, 8'd0, 2'b01, 3'd2, 32'hAABBCCDD, 4'hF, 0, 0, br, beats);
    void'(mdl_write(32'h0, 8'd0, 2'b01, 32'hAABBCCDD, 4'hF, 0));
    do_write(32'h0, 8'd0, 2'b01, 3'd3, 32'h11223344, 4'b0101, 0, 0, br, beats);
    void'(mdl_write(32'h0, 8'd0, 2'b01, 32'h11223344, 4'b0101, 0));
    chk("strb_bresp", br, 2'b00);
    do_read(32'h0, 8'd0, 2'b01, 3'd4, 1'b0);
    chk("strb_beats", got_d.size(), 1);
    if (got_d.size() > 0) begin
      chk("strb_rdata", got_d[0], 32'hAA22CC44);
      chk("strb_rresp", got_r[0], 2'b00);
    end

    // Early wlast: the burst still runs its full length, then bvalid waits for bready.
    do_write(32'h100, 8'd2, 2'b01, 3'd5, 32'hC0, 4'hF, 1, 5, br, beats);
    void'(mdl_write(32'h100, 8'd2, 2'b01, 32'hC0, 4'hF, 1));
    chk("wlast_early_beats", beats, 3);
    chk("wlast_early_bresp", br, 2'b10);
    do_write(32'h110, 8'd1, 2'b01, 3'd6, 32'hD0, 4'hF, -1, 1, br, beats);
    void'(mdl_write(32'h110, 8'd1, 2'b01, 32'hD0, 4'hF, -1));
    chk("wlast_missing_bresp", br, 2'b10);
    do_read(32'h100, 8'd3, 2'b01, 3'd7, 1'b0);
    check_read_mdl(32'h100, 8'd3, 2'b01);

    // Reset in the middle of a stalled read burst.
    s_axi_arid = 3'd2; s_axi_araddr = 32'h10; s_axi_arlen = 8'd7; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_arvalid = 1'b0;
    @(negedge s_axi_aclk);
    chk("midrst_rvalid_before", s_axi_rvalid, 1);
    s_axi_areset = 1'b1;
    #1;
    chk("midrst_rvalid", s_axi_rvalid, 0);
    chk("midrst_awready", s_axi_awready, 0);
    chk("midrst_arready", s_axi_arready, 0);
    @(negedge s_axi_aclk);
    chk("midrst_rvalid_hold", s_axi_rvalid, 0);
    chk("midrst_arready_hold", s_axi_arready, 0);
    s_axi_areset = 1'b0;
    do_read(32'h10, 8'd1, 2'b01, 3'd3, 1'b0);
    check_read_mdl(32'h10, 8'd1, 2'b01);

    // Random traffic against the model, including out-of-range and address wrap at 2^32.
    for (int t = 0; t < 60; t++) begin
      ra  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, DEPTH * 4 + 40));
      rl  = ($urandom_range(0, 5) == 0) ? 8'd15 : 8'($urandom_range(0, 7));
      rbu = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        rb = $urandom;
        wl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'(rl);
        do_write(ra, rl, rbu, 3'($urandom_range(0, 7)), rb, 4'($urandom_range(0, 15)), wl,
                 int'($urandom_range(0, 2)), br, beats);
        chk($sformatf("rnd%0d_bresp", t), br, mdl_write(ra, rl, rbu, rb, s_axi_wstrb, wl));
        chk($sformatf("rnd%0d_wbeats", t), beats, int'(rl) + 1);
      end else begin
        do_read(ra, rl, rbu, 3'($urandom_range(0, 7)), 1'b1);
        check_read_mdl(ra, rl, rbu);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
